// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin burst arbiter.
// State encodings, requester count and pointer reset value.
package mux4_rr_arbiter_pkg;

  localparam int NREQ = 4;

  localparam logic [1:0] PTR_RST = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// Single-bit 4:1 mux built as a tree of 2:1 stages.
// Each leaf stage has its own select so callers may drive them apart.
module mux4_rr_arbiter_mux4 (
  input  logic [3:0] d,
  input  logic       s0a,
  input  logic       s0b,
  input  logic       s1,
  output logic       y
);

  logic lo;
  logic hi;

  assign lo = s0a ? d[1] : d[0];
  assign hi = s0b ? d[3] : d[2];
  assign y  = s1  ? hi   : lo;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst arbiter steering four valid/ready streams
// onto one output channel; grant locks until the last beat.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ-1:0]       in_last,
  input  logic [NREQ*WIDTH-1:0] in_data,
  output logic [NREQ-1:0]       in_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [NREQ-1:0]       grant,
  output logic [1:0]            sel,
  output logic                  busy
);

  state_t          state_q;
  state_t          state_d;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] grant_d;
  logic [1:0]      sel_q;
  logic [1:0]      sel_d;
  logic [1:0]      ptr_q;
  logic [1:0]      ptr_d;

  logic [WIDTH-1:0] mux_data;
  logic             mux_last;
  logic             xfer;
  logic             found;
  logic [1:0]       cand;

  for (genvar b = 0; b < WIDTH; b++) begin : g_data
    mux4_rr_arbiter_mux4 u_mux (
      .d   ({in_data[3*WIDTH+b],
             in_data[2*WIDTH+b],
             in_data[WIDTH+b],
             in_data[b]}),
      .s0a (sel_q[0]),
      .s0b (sel_q[0]),
      .s1  (sel_q[1]),
      .y   (mux_data[b])
    );
  end

  mux4_rr_arbiter_mux4 u_last (
    .d   (in_last),
    .s0a (sel_q[0]),
    .s0b (sel_q[0]),
    .s1  (sel_q[1]),
    .y   (mux_last)
  );

  assign busy      = (state_q == BUSY);
  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_data  = mux_data;
  assign out_valid = busy & in_valid[sel_q];
  assign out_last  = busy & mux_last;
  assign in_ready  = grant_q & {NREQ{busy & out_ready}};
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    cand    = 2'd0;
    unique case (state_q)
      IDLE: begin
        // search ptr+1 .. ptr+4, wrapping
        for (int k = 1; k <= NREQ; k++) begin
          cand = ptr_q + 2'(k);
          if (!found && in_valid[cand]) begin
            found   = 1'b1;
            sel_d   = cand;
            grant_d = 4'b0001 << cand;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (xfer && out_last) begin
          ptr_d   = sel_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: per-requester beat sources,
// expected output beats queued in arbitration order.
module tb_mux4_rr_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   in_valid;
  logic [3:0]   in_last;
  logic [4*W-1:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic         out_last;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [3:0]   grant;
  logic [1:0]   sel;
  logic         busy;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0] req;
    logic       last;
    logic [7:0] data;
  } beat_t;

  beat_t      sb[$];
  logic [8:0] srcq[4][$];
  logic [3:0] gtrace[$];
  logic [3:0] vmask = 4'hF;
  logic       rdy = 1'b1;

  mux4_rr_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic src(input int r, input logic [7:0] d,
                     input logic l);
    srcq[r].push_back({l, d});
  endtask

  task automatic expect_beat(input int r, input logic [7:0] d,
                             input logic l);
    beat_t e;
    e.req  = 2'(r);
    e.last = l;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (srcq[i].size() != 0) begin
        in_valid[i]       = vmask[i];
        in_last[i]        = srcq[i][0][8];
        in_data[i*W +: W] = srcq[i][0][7:0];
      end else begin
        in_valid[i]       = 1'b0;
        in_last[i]        = 1'b0;
        in_data[i*W +: W] = '0;
      end
    end
    out_ready = rdy;
  endtask

  task automatic tick();
    logic [3:0] hs;
    beat_t e;
    @(negedge clk);
    hs = in_valid & in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("extra_beat", 32'(out_data), 32'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("data", 32'(out_data), 32'(e.data));
        chk("last", 32'(out_last), 32'(e.last));
        chk("sel", 32'(sel), 32'(e.req));
      end
    end
    gtrace.push_back(grant);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (hs[i]) void'(srcq[i].pop_front());
    drive();
    #1;
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0)
      chk("timeout", 32'(sb.size()), 0);
    for (int i = 0; i < 4; i++)
      chk("src_drain", 32'(srcq[i].size()), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) srcq[i].delete();
    sb.delete();
    vmask = 4'hF;
    rdy = 1'b1;
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp1 [5] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
  logic [3:0] exp2 [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0,
                            4'h4, 4'h0, 4'h8, 4'h0, 4'h1};

  initial begin
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    do_reset();

    chk("rst_grant", 32'(grant), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_olast", 32'(out_last), 0);
    chk("rst_iready", 32'(in_ready), 0);

    // single requester 3-beat burst
    src(2, 8'hA1, 1'b0);
    src(2, 8'hA2, 1'b0);
    src(2, 8'hA3, 1'b1);
    expect_beat(2, 8'hA1, 1'b0);
    expect_beat(2, 8'hA2, 1'b0);
    expect_beat(2, 8'hA3, 1'b1);
    gtrace.delete();
    drive();
    repeat (5) tick();
    for (int i = 0; i < 5; i++)
      chk($sformatf("t1_grant%0d", i), 32'(gtrace[i]), 32'(exp1[i]));
    chk("t1_sb", 32'(sb.size()), 0);

    // ptr now 2: order 3,0,1
    src(0, 8'h10, 1'b1);
    src(1, 8'h11, 1'b1);
    src(3, 8'h13, 1'b1);
    expect_beat(3, 8'h13, 1'b1);
    expect_beat(0, 8'h10, 1'b1);
    expect_beat(1, 8'h11, 1'b1);
    drive();
    run_until_empty(20);

    // all requesters from reset, single beats
    do_reset();
    src(0, 8'h20, 1'b1);
    src(0, 8'h24, 1'b1);
    src(1, 8'h21, 1'b1);
    src(2, 8'h22, 1'b1);
    src(3, 8'h23, 1'b1);
    expect_beat(0, 8'h20, 1'b1);
    expect_beat(1, 8'h21, 1'b1);
    expect_beat(2, 8'h22, 1'b1);
    expect_beat(3, 8'h23, 1'b1);
    expect_beat(0, 8'h24, 1'b1);
    gtrace.delete();
    drive();
    repeat (10) tick();
    for (int i = 0; i < 10; i++)
      chk($sformatf("t2_grant%0d", i), 32'(gtrace[i]), 32'(exp2[i]));
    run_until_empty(10);

    // backpressure mid-burst, ptr=0 so r1 wins
    for (int i = 0; i < 4; i++)
      src(1, 8'(8'h30 + i), 1'(i == 3));
    for (int i = 0; i < 4; i++)
      expect_beat(1, 8'(8'h30 + i), 1'(i == 3));
    drive();
    repeat (3) tick();
    rdy = 1'b0;
    drive();
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_grant", 32'(grant), 32'h2);
      chk("bp_iready", 32'(in_ready), 0);
      chk("bp_data", 32'(out_data), 32'h32);
      chk("bp_ovalid", 32'(out_valid), 1);
      tick();
    end
    rdy = 1'b1;
    drive();
    run_until_empty(20);

    // granted requester stalls, ptr=1 so r2 wins
    src(2, 8'h40, 1'b0);
    src(2, 8'h41, 1'b0);
    src(2, 8'h42, 1'b1);
    src(3, 8'h43, 1'b1);
    src(0, 8'h44, 1'b1);
    expect_beat(2, 8'h40, 1'b0);
    expect_beat(2, 8'h41, 1'b0);
    expect_beat(2, 8'h42, 1'b1);
    expect_beat(3, 8'h43, 1'b1);
    expect_beat(0, 8'h44, 1'b1);
    drive();
    repeat (2) tick();
    vmask = 4'b1011;
    drive();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_grant", 32'(grant), 32'h4);
      chk("stall_ovalid", 32'(out_valid), 0);
      tick();
    end
    vmask = 4'hF;
    drive();
    run_until_empty(30);

    // r1 finishes while r1,r2 valid: r2 next
    src(1, 8'h50, 1'b0);
    src(1, 8'h51, 1'b1);
    src(1, 8'h52, 1'b1);
    src(2, 8'h53, 1'b1);
    expect_beat(1, 8'h50, 1'b0);
    expect_beat(1, 8'h51, 1'b1);
    expect_beat(2, 8'h53, 1'b1);
    expect_beat(1, 8'h52, 1'b1);
    drive();
    run_until_empty(30);

    // reset after 2 of 4 beats, ptr=1 so r3 alone wins
    for (int i = 0; i < 4; i++)
      src(3, 8'(8'h60 + i), 1'(i == 3));
    expect_beat(3, 8'h60, 1'b0);
    expect_beat(3, 8'h61, 1'b0);
    drive();
    repeat (3) tick();
    chk("pre_rst_grant", 32'(grant), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_ovalid", 32'(out_valid), 0);
    chk("mid_rst_iready", 32'(in_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_sb", 32'(sb.size()), 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src(i, 8'(8'h70 + i), 1'b1);
      expect_beat(i, 8'(8'h70 + i), 1'b1);
    end
    drive();
    run_until_empty(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
